pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- IF-stage front end of the pipelined MIPS core.
- Owns the program counter and issues instruction-memory reads with a req/ready handshake.
- Loads the IF/ID pipeline register.
- Consumes the next-PC selection (pc_src: sequential / branch / jump) resolved downstream, with the same 2-bit select semantics as mux_2bit.

Parameters:
- BITS, 31, MSB index of address/instruction buses (bus width BITS+1).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pc_src  input  2  0=PC+4, 1=branch_target, 2 or 3=jump_target; nonzero means redirect/flush
- branch_target  input  BITS+1  branch target address
- jump_target  input  BITS+1  jump target address
- stall  input  1  ID not accepting; freeze PC and IF/ID register
- imem_req  output  1  instruction read request
- imem_addr  output  BITS+1  read address (current PC)
- imem_ready  input  1  imem_rdata valid this cycle; completes the request
- imem_rdata  input  BITS+1  fetched instruction
- if_valid  output  1  IF/ID register holds a live instruction
- if_pc  output  BITS+1  PC of the instruction in IF/ID
- if_pc_plus4  output  BITS+1  if_pc+4, for link/branch computation
- if_instr  output  BITS+1  instruction word; NOP (0) when not valid
- perf_wait_cycles  output  32  memory-wait counter (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0, kill=0, hold buffer empty, perf_wait_cycles=0.
- States: IDLE, FETCH, HOLD.
  - IDLE: first clock after reset release goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Address stays stable until imem_ready.
  - HOLD: imem_req=0. A completed instruction is buffered while stall=1.
- Next PC: pc_src==0 gives pc+4 (mod 2^32, wraps 0xFFFF_FFFC to 0). pc_src==1 gives branch_target. pc_src 2 or 3 gives jump_target. Target bits [1:0] are forced to 00.
- FETCH, imem_ready=1, stall=0, no redirect, kill=0:
  - IF/ID <= {valid=1, pc, pc+4, imem_rdata}; pc <= pc+4.
  - Stays in FETCH; the next request is issued on the following cycle with the new address.
  - Throughput is 1 instruction/cycle with a zero-wait memory.
- FETCH, imem_ready=1, stall=1: rdata captured into the hold buffer, go to HOLD. IF/ID and pc unchanged.
- HOLD, stall drops: buffer loads IF/ID, pc <= pc+4, return to FETCH. Latency is one cycle after stall deasserts.
- Stall with no ready: IF/ID and pc frozen; an outstanding request stays asserted.
- Redirect (pc_src!=0):
  - Has priority over stall.
  - pc <= target and if_valid <= 0 (bubble, if_instr=0) on that edge.
  - Clears the hold buffer (HOLD -> FETCH).
- Redirect in FETCH with the request outstanding (imem_ready=0):
  - Address is not changed. kill set.
  - The returning word is discarded on ready, kill cleared, and the new pc is requested next cycle.
- Redirect in the same cycle as imem_ready: the word is discarded, no kill needed.
- Simultaneous redirect and stall: redirect wins and IF/ID becomes a bubble.
- Reset mid-request: all state is dropped. A late imem_ready after reset release, before the first request, is ignored.

Optional Feature:
- Macro FETCH_STALL_COUNT_EN.
- Defined: perf_wait_cycles increments (saturating at 0xFFFF_FFFF) each cycle imem_req=1 and imem_ready=0. Cleared only by reset.
- Undefined: counter logic is absent and perf_wait_cycles is tied to 0. The port is present in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - PC_INC=4
  - NOP_INSTR=32'h0
  - pc_src encodings PCSRC_SEQ/PCSRC_BR/PCSRC_JMP
  - fetch state encoding IDLE/FETCH/HOLD
- Target selection reuses the existing mux_2bit (BITS=31) instance. No new sub-module.
- The FSM, hold buffer and IF/ID register stay in pc_fetch_stage.

Test Plan:
- Reset release, imem_ready tied 1, instructions 0x11,0x22,0x33 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; if_pc/if_instr follow one cycle later with if_valid=1.
- stall=1 for 3 cycles while ready pulses with 0xAB at pc 0x8 -> if_pc/if_instr frozen, imem_req=0 in HOLD. After stall drops, if_instr=0xAB, if_pc=0x8 the next cycle, then the fetch of 0xC.
- pc_src=1, branch_target=0x103 while ready=1 -> bubble (if_valid=0, if_instr=0), next imem_addr=0x100.
- pc_src=2, jump_target=0x400 while the request to 0x10 is outstanding (ready low 2 more cycles) -> imem_addr stays 0x10 until ready, returned word discarded, then imem_addr=0x400.
- RESET_PC=0xFFFF_FFFC, ready=1 -> second fetch address wraps to 0x0.
- FETCH_STALL_COUNT_EN defined, ready low 5 cycles during one request -> perf_wait_cycles=5. Undefined build -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: PC increment, NOP encoding, next-PC select codes
// and the fetch-stage state encoding.
package mips_pkg;

    localparam int unsigned PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_JMP = 2'd2
    } pcsrc_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/mux_2bit.sv
// Four-input multiplexer with a 2-bit select; used for next-PC target selection.
module mux_2bit #(
    parameter int BITS = 31
) (
    input  logic [1:0]    i_sel,
    input  logic [BITS:0] i_a,
    input  logic [BITS:0] i_b,
    input  logic [BITS:0] i_c,
    input  logic [BITS:0] i_d,
    output logic [BITS:0] o_y
);

    always_comb begin
        o_y = i_a;
        case (i_sel)
            2'd0:    o_y = i_a;
            2'd1:    o_y = i_b;
            2'd2:    o_y = i_c;
            default: o_y = i_d;
        endcase
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// IF stage: program counter, instruction-memory req/ready handshake, hold buffer
// and IF/ID register. Build option FETCH_STALL_COUNT_EN enables the memory-wait counter.
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter int            BITS     = 31,
    parameter logic [BITS:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    pc_src,
    input  logic [BITS:0] branch_target,
    input  logic [BITS:0] jump_target,
    input  logic          stall,
    output logic          imem_req,
    output logic [BITS:0] imem_addr,
    input  logic          imem_ready,
    input  logic [BITS:0] imem_rdata,
    output logic          if_valid,
    output logic [BITS:0] if_pc,
    output logic [BITS:0] if_pc_plus4,
    output logic [BITS:0] if_instr,
    output logic [31:0]   perf_wait_cycles
);

    localparam logic [BITS:0] W_INC = (BITS+1)'(PC_INC);
    localparam logic [BITS:0] W_NOP = (BITS+1)'(NOP_INSTR);

    fetch_state_e  r_state, w_state_next;
    logic [BITS:0] r_pc, w_pc_next;
    logic          r_kill, w_kill_next;
    logic [BITS:0] r_kill_addr, w_kill_addr_next;
    logic [BITS:0] r_hold_instr, w_hold_instr_next;
    logic          r_if_valid, w_if_valid_next;
    logic [BITS:0] r_if_pc, w_if_pc_next;
    logic [BITS:0] r_if_pc_plus4, w_if_pc_plus4_next;
    logic [BITS:0] r_if_instr, w_if_instr_next;

    logic [BITS:0] w_pc_plus4;
    logic [BITS:0] w_mux_y;
    logic [BITS:0] w_target;
    logic          w_redirect;

    assign w_pc_plus4 = r_pc + W_INC;
    assign w_redirect = (pc_src != PCSRC_SEQ);

    mux_2bit #(
        .BITS (BITS)
    ) u_next_pc_mux (
        .i_sel (pc_src),
        .i_a   (w_pc_plus4),
        .i_b   (branch_target),
        .i_c   (jump_target),
        .i_d   (jump_target),
        .o_y   (w_mux_y)
    );

    // Redirect targets are always word aligned.
    assign w_target = {w_mux_y[BITS:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_kill_addr   <= '0;
            r_hold_instr  <= '0;
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_if_instr    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_kill        <= w_kill_next;
            r_kill_addr   <= w_kill_addr_next;
            r_hold_instr  <= w_hold_instr_next;
            r_if_valid    <= w_if_valid_next;
            r_if_pc       <= w_if_pc_next;
            r_if_pc_plus4 <= w_if_pc_plus4_next;
            r_if_instr    <= w_if_instr_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_kill_next        = r_kill;
        w_kill_addr_next   = r_kill_addr;
        w_hold_instr_next  = r_hold_instr;
        w_if_valid_next    = r_if_valid;
        w_if_pc_next       = r_if_pc;
        w_if_pc_plus4_next = r_if_pc_plus4;
        w_if_instr_next    = r_if_instr;
        imem_req           = 1'b0;

        // When ID is not stalled it consumes IF/ID, so a bubble is the default refill.
        if (w_redirect || !stall) begin
            w_if_valid_next = 1'b0;
            w_if_instr_next = W_NOP;
        end

        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
                if (w_redirect) begin
                    w_pc_next = w_target;
                end
            end

            FETCH: begin
                imem_req = 1'b1;
                if (r_kill) begin
                    // Outstanding word belongs to a squashed path; drop it on return.
                    if (imem_ready) begin
                        w_kill_next = 1'b0;
                    end
                    if (w_redirect) begin
                        w_pc_next = w_target;
                    end
                end else if (w_redirect) begin
                    w_pc_next = w_target;
                    if (!imem_ready) begin
                        w_kill_next      = 1'b1;
                        w_kill_addr_next = r_pc;
                    end
                end else if (imem_ready && !stall) begin
                    w_if_valid_next    = 1'b1;
                    w_if_pc_next       = r_pc;
                    w_if_pc_plus4_next = w_pc_plus4;
                    w_if_instr_next    = imem_rdata;
                    w_pc_next          = w_pc_plus4;
                end else if (imem_ready) begin
                    w_hold_instr_next = imem_rdata;
                    w_state_next      = HOLD;
                end
            end

            HOLD: begin
                if (w_redirect) begin
                    w_pc_next         = w_target;
                    w_hold_instr_next = '0;
                    w_state_next      = FETCH;
                end else if (!stall) begin
                    w_if_valid_next    = 1'b1;
                    w_if_pc_next       = r_pc;
                    w_if_pc_plus4_next = w_pc_plus4;
                    w_if_instr_next    = r_hold_instr;
                    w_pc_next          = w_pc_plus4;
                    w_hold_instr_next  = '0;
                    w_state_next       = FETCH;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // While a killed request is outstanding the bus keeps the original address.
    assign imem_addr   = r_kill ? r_kill_addr : r_pc;
    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_instr    = r_if_instr;

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_wait <= '0;
        end else if (imem_req && !imem_ready && (r_perf_wait != 32'hFFFF_FFFF)) begin
            r_perf_wait <= r_perf_wait + 32'd1;
        end
    end

    assign perf_wait_cycles = r_perf_wait;
`else
    assign perf_wait_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage (main instance at PC 0, second
// instance at RESET_PC 0xFFFF_FFFC for the wrap case).
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic [31:0] perf_wait_cycles;

    logic [1:0]  wr_pc_src;
    logic [31:0] wr_target;
    logic        wr_stall;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_ready;
    logic [31:0] wr_rdata;
    logic        wr_valid;
    logic [31:0] wr_if_pc;
    logic [31:0] wr_if_pc_plus4;
    logic [31:0] wr_if_instr;
    logic [31:0] wr_perf;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_perf;

    pc_fetch_stage #(
        .BITS     (31),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .jump_target      (jump_target),
        .stall            (stall),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4),
        .if_instr         (if_instr),
        .perf_wait_cycles (perf_wait_cycles)
    );

    pc_fetch_stage #(
        .BITS     (31),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_src           (wr_pc_src),
        .branch_target    (wr_target),
        .jump_target      (wr_target),
        .stall            (wr_stall),
        .imem_req         (wr_req),
        .imem_addr        (wr_addr),
        .imem_ready       (wr_ready),
        .imem_rdata       (wr_rdata),
        .if_valid         (wr_valid),
        .if_pc            (wr_if_pc),
        .if_pc_plus4      (wr_if_pc_plus4),
        .if_instr         (wr_if_instr),
        .perf_wait_cycles (wr_perf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            $display("check %-22s observed=%08h expected=%08h ok", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef FETCH_STALL_COUNT_EN
        exp_perf = 5;
`else
        exp_perf = 0;
`endif
        rst_n = 1'b0;  pc_src = 2'd0;  branch_target = '0;  jump_target = '0;
        stall = 1'b0;  imem_ready = 1'b0;  imem_rdata = '0;
        wr_pc_src = 2'd0;  wr_target = '0;  wr_stall = 1'b0;  wr_ready = 1'b1;
        wr_rdata = 32'h0000_0099;
        tick();
        tick();
        check("rst_req",        {31'd0, imem_req}, 32'd0);
        check("rst_valid",      {31'd0, if_valid}, 32'd0);
        check("rst_if_pc",      if_pc,             32'd0);
        check("rst_if_pc4",     if_pc_plus4,       32'd0);
        check("rst_if_instr",   if_instr,          32'd0);
        check("rst_perf",       perf_wait_cycles,  32'd0);
        check("rst_wrap_addr",  wr_addr,           32'hFFFF_FFFC);

        // Sequential stream with a zero-wait memory; ready in IDLE must be ignored.
        rst_n = 1'b1;  imem_ready = 1'b1;  imem_rdata = 32'h0000_0BAD;
        tick();
        check("late_ready_ign", {31'd0, if_valid}, 32'd0);
        check("seq_req",        {31'd0, imem_req}, 32'd1);
        check("seq_addr0",      imem_addr,         32'h0);
        check("wrap_addr0",     wr_addr,           32'hFFFF_FFFC);
        imem_rdata = 32'h11;
        tick();
        check("seq_valid0",     {31'd0, if_valid}, 32'd1);
        check("seq_if_pc0",     if_pc,             32'h0);
        check("seq_if_pc4_0",   if_pc_plus4,       32'h4);
        check("seq_instr0",     if_instr,          32'h11);
        check("seq_addr1",      imem_addr,         32'h4);
        check("wrap_addr1",     wr_addr,           32'h0);
        check("wrap_if_pc",     wr_if_pc,          32'hFFFF_FFFC);
        check("wrap_if_pc4",    wr_if_pc_plus4,    32'h0);
        imem_rdata = 32'h22;
        tick();
        check("seq_if_pc1",     if_pc,             32'h4);
        check("seq_instr1",     if_instr,          32'h22);
        check("seq_addr2",      imem_addr,         32'h8);
        imem_rdata = 32'h33;
        tick();
        check("seq_if_pc2",     if_pc,             32'h8);
        check("seq_instr2",     if_instr,          32'h33);
        check("seq_addr3",      imem_addr,         32'hC);

        // Stall while the word at 0x8 returns: buffered in HOLD, delivered after release.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        imem_rdata = 32'h11;
        tick();
        imem_rdata = 32'h22;
        tick();
        stall = 1'b1;  imem_rdata = 32'hAB;
        tick();
        check("hold_req0",      {31'd0, imem_req}, 32'd0);
        check("hold_if_pc0",    if_pc,             32'h4);
        check("hold_instr0",    if_instr,          32'h22);
        check("hold_valid0",    {31'd0, if_valid}, 32'd1);
        imem_ready = 1'b0;
        tick();
        check("hold_req1",      {31'd0, imem_req}, 32'd0);
        check("hold_instr1",    if_instr,          32'h22);
        tick();
        check("hold_req2",      {31'd0, imem_req}, 32'd0);
        check("hold_if_pc2",    if_pc,             32'h4);
        stall = 1'b0;
        tick();
        check("unhold_valid",   {31'd0, if_valid}, 32'd1);
        check("unhold_if_pc",   if_pc,             32'h8);
        check("unhold_instr",   if_instr,          32'hAB);
        check("unhold_req",     {31'd0, imem_req}, 32'd1);
        check("unhold_addr",    imem_addr,         32'hC);
        imem_ready = 1'b1;  imem_rdata = 32'hCC;
        tick();
        check("after_hold_pc",  if_pc,             32'hC);
        check("after_hold_ins", if_instr,          32'hCC);
        check("after_hold_adr", imem_addr,         32'h10);

        // Jump while the request to 0x10 is outstanding: address held, word killed.
        imem_ready = 1'b0;
        tick();
        check("pend_addr",      imem_addr,         32'h10);
        pc_src = 2'd2;  jump_target = 32'h400;
        tick();
        check("kill_addr0",     imem_addr,         32'h10);
        check("kill_req0",      {31'd0, imem_req}, 32'd1);
        check("kill_valid0",    {31'd0, if_valid}, 32'd0);
        check("kill_instr0",    if_instr,          32'h0);
        pc_src = 2'd0;
        tick();
        check("kill_addr1",     imem_addr,         32'h10);
        tick();
        check("kill_addr2",     imem_addr,         32'h10);
        imem_ready = 1'b1;  imem_rdata = 32'hDEAD;
        tick();
        check("kill_drop_val",  {31'd0, if_valid}, 32'd0);
        check("kill_drop_ins",  if_instr,          32'h0);
        check("jump_addr",      imem_addr,         32'h400);
        imem_rdata = 32'h77;
        tick();
        check("jump_if_pc",     if_pc,             32'h400);
        check("jump_instr",     if_instr,          32'h77);
        check("jump_addr_next", imem_addr,         32'h404);

        // Branch with ready high: bubble, misaligned target forced to 0x100.
        pc_src = 2'd1;  branch_target = 32'h103;  imem_rdata = 32'h88;
        tick();
        check("br_valid",       {31'd0, if_valid}, 32'd0);
        check("br_instr",       if_instr,          32'h0);
        check("br_addr",        imem_addr,         32'h100);
        pc_src = 2'd0;  imem_rdata = 32'h55;
        tick();
        check("br_if_pc",       if_pc,             32'h100);
        check("br_instr_next",  if_instr,          32'h55);
        check("br_addr_next",   imem_addr,         32'h104);

        // Redirect and stall together: redirect wins, no HOLD entered.
        stall = 1'b1;  pc_src = 2'd3;  jump_target = 32'h202;  imem_rdata = 32'h99;
        tick();
        check("rs_valid",       {31'd0, if_valid}, 32'd0);
        check("rs_instr",       if_instr,          32'h0);
        check("rs_req",         {31'd0, imem_req}, 32'd1);
        check("rs_addr",        imem_addr,         32'h200);
        stall = 1'b0;  pc_src = 2'd0;  imem_rdata = 32'h66;
        tick();
        check("rs_if_pc",       if_pc,             32'h200);
        check("rs_instr_next",  if_instr,          32'h66);

        // Wait counter: five wait cycles on a single request.
        imem_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        check("perf_rst",       perf_wait_cycles,  32'd0);
        rst_n = 1'b1;
        tick();
        check("perf_start",     perf_wait_cycles,  32'd0);
        repeat (5) tick();
        check("perf_wait5",     perf_wait_cycles,  32'(exp_perf));
        check("perf_addr",      imem_addr,         32'h0);
        imem_ready = 1'b1;  imem_rdata = 32'h44;
        tick();
        check("perf_after",     perf_wait_cycles,  32'(exp_perf));
        check("perf_instr",     if_instr,          32'h44);
        check("perf_if_pc",     if_pc,             32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
